// File: rtl/sram_avalon_bridge.sv
// sram_avalon_bridge: Avalon-MM slave to asynchronous 16-bit SRAM bridge
// Ports: i_clk/i_rst_n (sync active-low reset); avs_* Avalon-MM slave
// (address, byteenable, read, write, writedata, readdata, readdatavalid,
// waitrequest); SRAM_ADDR/SRAM_DQ and active-low SRAM_CE_N/OE_N/WE_N/UB_N/LB_N.
// Optional: define SRAM_BRIDGE_STATS_EN to add o_rd_count/o_wr_count,
// saturating counters of completed reads and writes.
module sram_avalon_bridge #(
  parameter int READ_WAIT  = 1,
  parameter int WRITE_WAIT = 1
) (
  input  logic        i_clk,
  input  logic        i_rst_n,
  input  logic [19:0] avs_address,
  input  logic [1:0]  avs_byteenable,
  input  logic        avs_read,
  input  logic        avs_write,
  input  logic [15:0] avs_writedata,
  output logic [15:0] avs_readdata,
  output logic        avs_readdatavalid,
  output logic        avs_waitrequest,
  output logic [19:0] SRAM_ADDR,
  inout  wire  [15:0] SRAM_DQ,
  output logic        SRAM_CE_N,
  output logic        SRAM_OE_N,
  output logic        SRAM_WE_N,
  output logic        SRAM_UB_N,
`ifdef SRAM_BRIDGE_STATS_EN
  output logic [15:0] o_rd_count,
  output logic [15:0] o_wr_count,
`endif
  output logic        SRAM_LB_N
);
  typedef enum logic [2:0] {IDLE, RD_WAIT, RD_DONE, WR_PULSE, WR_HOLD} state_t;
  state_t      state_q, state_d;
  logic [3:0]  cnt_q, cnt_d;
  logic [19:0] addr_q;
  logic [15:0] wdata_q, rdata_q;
  logic [1:0]  be_q;
  logic        accept, last, rd_act, wr_act;
  always_comb begin
    accept  = state_q == IDLE && (avs_read || avs_write);
    // a write wins over a simultaneous read; the read is simply dropped
    last    = cnt_q == (state_q == RD_WAIT ? 4'(READ_WAIT - 1) : 4'(WRITE_WAIT - 1));
    state_d = accept ? (avs_write ? WR_PULSE : RD_WAIT)
            : state_q == RD_WAIT  ? (last ? RD_DONE : RD_WAIT)
            : state_q == WR_PULSE ? (last ? WR_HOLD : WR_PULSE)
            : IDLE;
    cnt_d   = ((state_q == RD_WAIT || state_q == WR_PULSE) && !last) ? cnt_q + 4'd1 : 4'd0;
  end
  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      state_q <= IDLE;
      cnt_q   <= 4'd0;
      addr_q  <= 20'd0;
      wdata_q <= 16'd0;
      be_q    <= 2'd0;
      rdata_q <= 16'd0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      if (accept) begin
        addr_q  <= avs_address;
        wdata_q <= avs_writedata;
        be_q    <= avs_byteenable;
      end
      if (state_q == RD_WAIT && last) rdata_q <= SRAM_DQ;
    end
  end
  assign rd_act            = state_q == RD_WAIT;
  assign wr_act            = state_q == WR_PULSE || state_q == WR_HOLD;
  assign avs_waitrequest   = state_q != IDLE;
  assign avs_readdatavalid = state_q == RD_DONE;
  assign avs_readdata      = rdata_q;
  assign SRAM_ADDR         = addr_q;
  assign SRAM_CE_N         = !(rd_act || wr_act);
  assign SRAM_OE_N         = !rd_act;
  assign SRAM_WE_N         = state_q != WR_PULSE;
  assign SRAM_UB_N         = rd_act ? 1'b0 : wr_act ? ~be_q[1] : 1'b1;
  assign SRAM_LB_N         = rd_act ? 1'b0 : wr_act ? ~be_q[0] : 1'b1;
  // data is driven only in write states, where OE_N is always high
  assign SRAM_DQ           = wr_act ? wdata_q : 16'hzzzz;
`ifdef SRAM_BRIDGE_STATS_EN
  logic [15:0] rd_cnt_q, wr_cnt_q;
  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      rd_cnt_q <= 16'd0;
      wr_cnt_q <= 16'd0;
    end else begin
      if (state_q == RD_DONE && rd_cnt_q != 16'hFFFF) rd_cnt_q <= rd_cnt_q + 16'd1;
      if (state_q == WR_HOLD && wr_cnt_q != 16'hFFFF) wr_cnt_q <= wr_cnt_q + 16'd1;
    end
  end
  assign o_rd_count = rd_cnt_q;
  assign o_wr_count = wr_cnt_q;
`endif
endmodule

// File: tb/tb_sram_avalon_bridge.sv
// tb_sram_avalon_bridge: directed self-checking bench for sram_avalon_bridge
module tb_sram_avalon_bridge;
  logic clk, rst_n;
  logic [19:0] a, a3;
  logic [1:0] be, be3;
  logic rd, wr, rd3, wr3;
  logic [15:0] wd, wd3;
  logic [15:0] rdata, rdata3;
  logic rv, rv3, wreq, wreq3;
  logic [19:0] sa, sa3;
  wire [15:0] dq, dq3;
  logic ce, oe, we, ub, lb, ce3, oe3, we3, ub3, lb3;
`ifdef SRAM_BRIDGE_STATS_EN
  logic [15:0] rc, wc, rc3, wc3;
`endif
  int tests = 0;
  int fails = 0;
  logic [15:0] mem [0:255];
  logic [15:0] mem3 [0:255];

  sram_avalon_bridge #(.READ_WAIT(1), .WRITE_WAIT(1)) dut (
    .i_clk(clk), .i_rst_n(rst_n), .avs_address(a), .avs_byteenable(be),
    .avs_read(rd), .avs_write(wr), .avs_writedata(wd), .avs_readdata(rdata),
    .avs_readdatavalid(rv), .avs_waitrequest(wreq), .SRAM_ADDR(sa), .SRAM_DQ(dq),
    .SRAM_CE_N(ce), .SRAM_OE_N(oe), .SRAM_WE_N(we), .SRAM_UB_N(ub),
`ifdef SRAM_BRIDGE_STATS_EN
    .o_rd_count(rc), .o_wr_count(wc),
`endif
    .SRAM_LB_N(lb));

  sram_avalon_bridge #(.READ_WAIT(3), .WRITE_WAIT(1)) dut3 (
    .i_clk(clk), .i_rst_n(rst_n), .avs_address(a3), .avs_byteenable(be3),
    .avs_read(rd3), .avs_write(wr3), .avs_writedata(wd3), .avs_readdata(rdata3),
    .avs_readdatavalid(rv3), .avs_waitrequest(wreq3), .SRAM_ADDR(sa3), .SRAM_DQ(dq3),
    .SRAM_CE_N(ce3), .SRAM_OE_N(oe3), .SRAM_WE_N(we3), .SRAM_UB_N(ub3),
`ifdef SRAM_BRIDGE_STATS_EN
    .o_rd_count(rc3), .o_wr_count(wc3),
`endif
    .SRAM_LB_N(lb3));

  assign dq  = (!ce && !oe && we) ? mem[sa[7:0]] : 16'hzzzz;
  assign dq3 = (!ce3 && !oe3 && we3) ? mem3[sa3[7:0]] : 16'hzzzz;
  always @(posedge clk) begin
    if (!ce && !we) begin
      if (!ub) mem[sa[7:0]][15:8] <= dq[15:8];
      if (!lb) mem[sa[7:0]][7:0] <= dq[7:0];
    end
    if (!ce3 && !we3) begin
      if (!ub3) mem3[sa3[7:0]][15:8] <= dq3[15:8];
      if (!lb3) mem3[sa3[7:0]][7:0] <= dq3[7:0];
    end
  end

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic cmd(input logic r, input logic w, input logic [19:0] ad, input logic [15:0] d, input logic [1:0] b);
    rd = r; wr = w; a = ad; wd = d; be = b;
    @(negedge clk);
    rd = 1'b0; wr = 1'b0;
  endtask

  task automatic do_write(input logic [19:0] ad, input logic [15:0] d, input logic [1:0] b);
    cmd(1'b0, 1'b1, ad, d, b);
    @(negedge clk);
    @(negedge clk);
  endtask

  task automatic do_read(input logic [19:0] ad, output logic v, output logic [15:0] d);
    cmd(1'b1, 1'b0, ad, 16'h0, 2'b00);
    @(negedge clk);
    v = rv; d = rdata;
    @(negedge clk);
  endtask

  task automatic test_reset;
    rst_n = 1'b0;
    @(negedge clk);
    @(negedge clk);
    tests++; if (rv !== 1'b0) begin fails++; $display("FAIL rst_valid got=%b exp=0", rv); end
    tests++; if (rdata !== 16'h0) begin fails++; $display("FAIL rst_rdata got=%h exp=0000", rdata); end
    tests++; if ({ce, oe, we, ub, lb} !== 5'b11111) begin fails++; $display("FAIL rst_strobes got=%b exp=11111", {ce, oe, we, ub, lb}); end
    tests++; if (sa !== 20'h0) begin fails++; $display("FAIL rst_addr got=%h exp=00000", sa); end
    tests++; if ({ce3, oe3, we3, ub3, lb3} !== 5'b11111) begin fails++; $display("FAIL rst_strobes3 got=%b exp=11111", {ce3, oe3, we3, ub3, lb3}); end
    rst_n = 1'b1;
    @(negedge clk);
    tests++; if (wreq !== 1'b0) begin fails++; $display("FAIL rst_wait got=%b exp=0", wreq); end
  endtask

  task automatic test_write_read;
    cmd(1'b0, 1'b1, 20'h00010, 16'h1234, 2'b11);
    tests++; if ({ce, oe, we, ub, lb} !== 5'b01000) begin fails++; $display("FAIL wr_pulse_strobes got=%b exp=01000", {ce, oe, we, ub, lb}); end
    tests++; if (dq !== 16'h1234) begin fails++; $display("FAIL wr_pulse_dq got=%h exp=1234", dq); end
    tests++; if (sa !== 20'h00010) begin fails++; $display("FAIL wr_addr got=%h exp=00010", sa); end
    tests++; if (wreq !== 1'b1) begin fails++; $display("FAIL wr_wait got=%b exp=1", wreq); end
    @(negedge clk);
    tests++; if ({ce, we} !== 2'b01) begin fails++; $display("FAIL wr_hold_ce_we got=%b exp=01", {ce, we}); end
    tests++; if (dq !== 16'h1234) begin fails++; $display("FAIL wr_hold_dq got=%h exp=1234", dq); end
    @(negedge clk);
    tests++; if ({wreq, ce, we} !== 3'b011) begin fails++; $display("FAIL wr_idle got=%b exp=011", {wreq, ce, we}); end
    cmd(1'b1, 1'b0, 20'h00010, 16'h0, 2'b00);
    tests++; if ({ce, oe, we, ub, lb} !== 5'b00100) begin fails++; $display("FAIL rd_strobes got=%b exp=00100", {ce, oe, we, ub, lb}); end
    tests++; if (rv !== 1'b0) begin fails++; $display("FAIL rd_early_valid got=%b exp=0", rv); end
    @(negedge clk);
    tests++; if (rv !== 1'b1) begin fails++; $display("FAIL rd_valid got=%b exp=1", rv); end
    tests++; if (rdata !== 16'h1234) begin fails++; $display("FAIL rd_data got=%h exp=1234", rdata); end
    @(negedge clk);
    tests++; if ({rv, wreq} !== 2'b00) begin fails++; $display("FAIL rd_after got=%b exp=00", {rv, wreq}); end
    tests++; if (rdata !== 16'h1234) begin fails++; $display("FAIL rd_hold_data got=%h exp=1234", rdata); end
  endtask

  task automatic test_byte_enable;
    logic v;
    logic [15:0] d;
    cmd(1'b0, 1'b1, 20'h00010, 16'hABCD, 2'b01);
    tests++; if ({we, ub, lb} !== 3'b010) begin fails++; $display("FAIL be01_lanes got=%b exp=010", {we, ub, lb}); end
    @(negedge clk);
    @(negedge clk);
    do_read(20'h00010, v, d);
    tests++; if ({v, d} !== {1'b1, 16'h12CD}) begin fails++; $display("FAIL be01_read got=%b/%h exp=1/12cd", v, d); end
    cmd(1'b0, 1'b1, 20'h00010, 16'hFFFF, 2'b00);
    tests++; if ({ce, we, ub, lb} !== 4'b0011) begin fails++; $display("FAIL be00_lanes got=%b exp=0011", {ce, we, ub, lb}); end
    @(negedge clk);
    tests++; if ({ce, we} !== 2'b01) begin fails++; $display("FAIL be00_hold got=%b exp=01", {ce, we}); end
    @(negedge clk);
    do_read(20'h00010, v, d);
    tests++; if (d !== 16'h12CD) begin fails++; $display("FAIL be00_read got=%h exp=12cd", d); end
  endtask

  task automatic test_rw_collision;
    int vc;
    logic v;
    logic [15:0] d;
    vc = 0;
    cmd(1'b1, 1'b1, 20'h00020, 16'h5555, 2'b11);
    tests++; if ({oe, we} !== 2'b10) begin fails++; $display("FAIL coll_write got=%b exp=10", {oe, we}); end
    vc += int'(rv);
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      vc += int'(rv);
    end
    tests++; if (vc !== 0) begin fails++; $display("FAIL coll_novalid got=%0d exp=0", vc); end
    do_read(20'h00020, v, d);
    tests++; if ({v, d} !== {1'b1, 16'h5555}) begin fails++; $display("FAIL coll_read got=%b/%h exp=1/5555", v, d); end
  endtask

  task automatic test_reset_abort;
    int vc;
    vc = 0;
    cmd(1'b1, 1'b0, 20'h00010, 16'h0, 2'b00);
    tests++; if (oe !== 1'b0) begin fails++; $display("FAIL abort_inread got=%b exp=0", oe); end
    rst_n = 1'b0;
    @(negedge clk);
    vc += int'(rv);
    tests++; if ({ce, oe, we, ub, lb} !== 5'b11111) begin fails++; $display("FAIL abort_strobes got=%b exp=11111", {ce, oe, we, ub, lb}); end
    rst_n = 1'b1;
    @(negedge clk);
    vc += int'(rv);
    tests++; if (wreq !== 1'b0) begin fails++; $display("FAIL abort_wait got=%b exp=0", wreq); end
    tests++; if ({ce, oe, we, ub, lb} !== 5'b11111) begin fails++; $display("FAIL abort_idle got=%b exp=11111", {ce, oe, we, ub, lb}); end
    @(negedge clk);
    vc += int'(rv);
    tests++; if (vc !== 0) begin fails++; $display("FAIL abort_novalid got=%0d exp=0", vc); end
    tests++; if (rdata !== 16'h0) begin fails++; $display("FAIL abort_rdata got=%h exp=0000", rdata); end
  endtask

  task automatic test_back_to_back;
    logic [10:0] wp, vp;
    logic [15:0] d;
    d = 16'h0;
    wr3 = 1'b1; a3 = 20'h00030; wd3 = 16'hBEEF; be3 = 2'b11;
    @(negedge clk);
    wr3 = 1'b0;
    @(negedge clk);
    @(negedge clk);
    rd3 = 1'b1;
    for (int k = 0; k < 11; k++) begin
      wp[k] = wreq3;
      vp[k] = rv3;
      if (rv3) d = rdata3;
      if (k < 10) @(negedge clk);
    end
    rd3 = 1'b0;
    @(negedge clk);
    tests++; if (wp !== 11'b01111011110) begin fails++; $display("FAIL b2b_wait got=%b exp=01111011110", wp); end
    tests++; if (vp !== 11'b01000010000) begin fails++; $display("FAIL b2b_valid got=%b exp=01000010000", vp); end
    tests++; if (d !== 16'hBEEF) begin fails++; $display("FAIL b2b_data got=%h exp=beef", d); end
    tests++; if (wreq3 !== 1'b0) begin fails++; $display("FAIL b2b_idle got=%b exp=0", wreq3); end
  endtask

`ifdef SRAM_BRIDGE_STATS_EN
  task automatic test_stats;
    logic v;
    logic [15:0] d;
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    tests++; if ({rc, wc} !== 32'h0) begin fails++; $display("FAIL stats_rst got=%h/%h exp=0/0", rc, wc); end
    do_write(20'h00001, 16'h1111, 2'b11);
    do_write(20'h00002, 16'h2222, 2'b11);
    do_write(20'h00003, 16'h3333, 2'b11);
    do_read(20'h00001, v, d);
    do_read(20'h00002, v, d);
    tests++; if (wc !== 16'd3) begin fails++; $display("FAIL stats_wr got=%0d exp=3", wc); end
    tests++; if (rc !== 16'd2) begin fails++; $display("FAIL stats_rd got=%0d exp=2", rc); end
    force dut.rd_cnt_q = 16'hFFFF;
    @(negedge clk);
    release dut.rd_cnt_q;
    do_read(20'h00001, v, d);
    tests++; if (rc !== 16'hFFFF) begin fails++; $display("FAIL stats_sat got=%h exp=ffff", rc); end
  endtask
`endif

  initial begin
    rst_n = 1'b0; rd = 1'b0; wr = 1'b0; a = 20'h0; wd = 16'h0; be = 2'b00;
    rd3 = 1'b0; wr3 = 1'b0; a3 = 20'h0; wd3 = 16'h0; be3 = 2'b00;
    @(negedge clk);
    test_reset;
    test_write_read;
    test_byte_enable;
    test_rw_collision;
    test_reset_abort;
    test_back_to_back;
`ifdef SRAM_BRIDGE_STATS_EN
    test_stats;
`endif
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule

// File: doc/sram_avalon_bridge.md
SRAM_AVALON_BRIDGE -- requirements
Module: sram_avalon_bridge

Interface
REQ-001 SHALL have parameter READ_WAIT, default 1, number of cycles OE_N held low before the read sample (legal 1..15).
REQ-002 SHALL have parameter WRITE_WAIT, default 1, number of cycles WE_N held low (legal 1..15).
REQ-003 SHALL have port i_clk  input  1  single clock; every register updates on the rising edge.
REQ-004 SHALL have port i_rst_n  input  1  reset, synchronous, active-low.
REQ-005 SHALL have port avs_address  input  20  SRAM word address; driven unchanged to SRAM_ADDR.
REQ-006 SHALL have port avs_byteenable  input  2  write lane enables; bit1 = upper byte, bit0 = lower byte.
REQ-007 SHALL have port avs_read  input  1  read request.
REQ-008 SHALL have port avs_write  input  1  write request.
REQ-009 SHALL have port avs_writedata  input  16  write data.
REQ-010 SHALL have port avs_readdata  output  16  read data; valid only while avs_readdatavalid=1.
REQ-011 SHALL have port avs_readdatavalid  output  1  one-cycle read-return strobe.
REQ-012 SHALL have port avs_waitrequest  output  1  1 = command not accepted this cycle.
REQ-013 SHALL have port SRAM_ADDR  output  20  SRAM address.
REQ-014 SHALL have port SRAM_DQ  inout  16  SRAM data bus.
REQ-015 SHALL have ports SRAM_CE_N, SRAM_OE_N, SRAM_WE_N, SRAM_UB_N, SRAM_LB_N  output  1 each  active-low SRAM strobes.

Function
REQ-016 SHALL implement the states IDLE, RD_WAIT, RD_DONE, WR_PULSE and WR_HOLD.
REQ-017 SHALL drive avs_waitrequest=0 only in IDLE; a command is accepted in the cycle it is present while in IDLE.
REQ-018 SHALL latch address, writedata and byteenable on acceptance and hold SRAM_ADDR stable until the return to IDLE.
REQ-019 SHALL go IDLE->RD_WAIT on an accepted read and stay READ_WAIT cycles with CE_N=0, OE_N=0, UB_N=LB_N=0 and DQ at high-Z.
REQ-020 SHALL capture SRAM_DQ into avs_readdata at the end of the last RD_WAIT cycle, then enter RD_DONE with avs_readdatavalid=1 for exactly one cycle, then return to IDLE.
REQ-021 SHALL give read latency = READ_WAIT+1 cycles from acceptance edge to avs_readdatavalid.
REQ-022 SHALL go IDLE->WR_PULSE on an accepted write and stay WRITE_WAIT cycles with CE_N=0, WE_N=0, OE_N=1, UB_N=~be[1], LB_N=~be[0] and DQ driven with the latched data.
REQ-023 SHALL follow WR_PULSE with one WR_HOLD cycle (WE_N=1, CE_N=0, DQ still driven), then return to IDLE.
REQ-024 SHALL allow the next command to be accepted WRITE_WAIT+2 cycles after a write acceptance, and READ_WAIT+2 cycles after a read acceptance.
REQ-025 SHALL, when avs_byteenable=2'b00 on a write, run the full write timing with UB_N=LB_N=1, so that no SRAM byte changes.
REQ-026 SHALL, when avs_read and avs_write are both 1 in IDLE, perform the write only; the read is dropped and produces no avs_readdatavalid.
REQ-027 SHALL keep avs_readdata unchanged between reads.
REQ-028 SHALL, in IDLE, drive CE_N=OE_N=WE_N=UB_N=LB_N=1 and DQ at high-Z.
REQ-029 SHALL never drive DQ while OE_N=0.

Reset
REQ-030 SHALL, on i_rst_n=0 at a clock edge, enter IDLE with avs_readdatavalid=0, avs_readdata=0, all SRAM strobes=1, SRAM_ADDR=0 and DQ at high-Z.
REQ-031 SHALL abort any in-flight operation on reset without issuing avs_readdatavalid for it; avs_waitrequest=0 from the first cycle after reset release.

Configuration
REQ-032 SHALL, when macro SRAM_BRIDGE_STATS_EN is defined, add outputs o_rd_count[15:0] and o_wr_count[15:0], which count completed reads (RD_DONE) and writes (WR_HOLD), saturate at 16'hFFFF and reset to 0.
REQ-033 SHALL, without SRAM_BRIDGE_STATS_EN, omit those ports and counters, leaving all other behaviour identical.

Verification
REQ-034 SHALL verify with READ_WAIT=1: write 0x1234 at address 0x00010 with be=11, then read 0x00010 -> readdatavalid exactly 2 cycles after acceptance, readdata=0x1234.
REQ-035 SHALL verify: write 0xABCD with be=01 over an existing 0x1234 -> the following read returns 0x12CD, and UB_N stayed 1 during WR_PULSE.
REQ-036 SHALL verify: read and write asserted together with address 0x00020 and data 0x5555 -> one write, no readdatavalid, next read returns 0x5555.
REQ-037 SHALL verify: i_rst_n pulled low during RD_WAIT -> no readdatavalid pulse, strobes=1 and waitrequest=0 after release.
REQ-038 SHALL verify with READ_WAIT=3: back-to-back reads held asserted -> waitrequest high 4 cycles per read, one readdatavalid per read, 5-cycle command spacing.
REQ-039 SHALL verify with SRAM_BRIDGE_STATS_EN: 3 writes and 2 reads -> o_wr_count=3, o_rd_count=2; preload 16'hFFFF and read again -> o_rd_count stays 16'hFFFF.
